instamp_sar_ctrl: RTL and testbench

- Digital readback controller for the on-chip instrumentation amplifier; it digitises the amplifier output.
- Drives the track/hold switch, the gain-select code and an R-2R DAC code.
- Reads the analog comparator decision (amp output > DAC) and runs a successive-approximation search.
- Optional autoranging steps amplifier gain on over-/under-range, then returns result and gain with a done pulse.

---
 rtl/instamp_sar_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_instamp_sar_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instamp_sar_ctrl.sv
// -----------------------------------------------------------------------------
// instamp_sar_ctrl
//
// Readback controller for the on-chip instrumentation amplifier. It tracks the
// amplifier output, holds it, and then runs a successive-approximation search
// against an R-2R DAC using the analog comparator. When autoranging is enabled,
// an over-range result lowers the gain and an under-range result raises it, and
// the sample is then retaken. When the search settles, the controller returns
// the code and the gain used, together with a one-cycle done pulse.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   start        conversion request (level, only looked at in IDLE)
//   autorange_en enables gain stepping between passes
//   comp         asynchronous comparator, 1 = amp output above dac_code
//   dac_code     DAC drive
//   sample       1 = track, 0 = hold
//   gain         amplifier gain select (0 = lowest, each step doubles)
//   busy         high from first SAMPLE cycle until done
//   done         one-cycle pulse, result fields valid
//   result       last converted code
//   result_gain  gain used for result
//   ovr / udr    result was all-ones / all-zeros at the final gain
// -----------------------------------------------------------------------------
module instamp_sar_ctrl #(
    parameter int WIDTH      = 8,
    parameter int GAIN_BITS  = 2,
    parameter int SAMPLE_CYC = 8,
    parameter int SETTLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 autorange_en,
    input  logic                 comp,
    output logic [WIDTH-1:0]     dac_code,
    output logic                 sample,
    output logic [GAIN_BITS-1:0] gain,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [GAIN_BITS-1:0] result_gain,
    output logic                 ovr,
    output logic                 udr
);

    localparam int CNT_MAX = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0]        SAMPLE_LAST = CW'(SAMPLE_CYC - 1);
    localparam logic [CW-1:0]        SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [BW-1:0]        BIT_TOP     = BW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]     UNDER_LIM   = WIDTH'(1) << (WIDTH - 2);
    localparam logic [GAIN_BITS-1:0] GAIN_MAX    = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CONV,
        ST_EVAL,
        ST_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [BW-1:0]        bit_reg, bit_next;
    logic [WIDTH-1:0]     code_reg, code_next;
    logic [GAIN_BITS-1:0] gain_reg, gain_next;
    logic                 down_reg, down_next;
    logic [WIDTH-1:0]     result_reg, result_next;
    logic [GAIN_BITS-1:0] result_gain_reg, result_gain_next;
    logic                 ovr_reg, ovr_next;
    logic                 udr_reg, udr_next;
    logic                 comp_meta_reg, comp_s_reg;

    logic [WIDTH-1:0]     bit_mask;
    logic                 over_range, under_range;

    // One-hot mask of the bit currently under trial.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign bit_mask[gi] = (bit_reg == BW'(gi));
        end
    endgenerate

    assign over_range  = &code_reg;
    assign under_range = (code_reg < UNDER_LIM);

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        bit_next         = bit_reg;
        code_next        = code_reg;
        gain_next        = gain_reg;
        down_next        = down_reg;
        result_next      = result_reg;
        result_gain_next = result_gain_reg;
        ovr_next         = ovr_reg;
        udr_next         = udr_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SAMPLE;
                    cnt_next   = '0;
                    code_next  = '0;
                    down_next  = 1'b0;
                end
            end
            ST_SAMPLE: begin
                if (cnt_reg == SAMPLE_LAST) begin
                    state_next = ST_CONV;
                    cnt_next   = '0;
                    bit_next   = BIT_TOP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_CONV: begin
                if (cnt_reg == SETTLE_LAST) begin
                    // Decide the trial bit with the synchronised comparator.
                    code_next = comp_s_reg ? (code_reg | bit_mask) : (code_reg & ~bit_mask);
                    cnt_next  = '0;
                    if (bit_reg == '0) begin
                        state_next = ST_EVAL;
                    end else begin
                        bit_next = bit_reg - 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_EVAL: begin
                if (autorange_en && over_range && (gain_reg != '0)) begin
                    gain_next  = gain_reg - 1'b1;
                    down_next  = 1'b1;
                    state_next = ST_SAMPLE;
                    cnt_next   = '0;
                    code_next  = '0;
                end else if (autorange_en && under_range && (gain_reg != GAIN_MAX) && !down_reg) begin
                    // Up-steps are locked out once this request has stepped down,
                    // so the gain cannot ping-pong between two settings.
                    gain_next  = gain_reg + 1'b1;
                    state_next = ST_SAMPLE;
                    cnt_next   = '0;
                    code_next  = '0;
                end else begin
                    // Load here so the fields are already valid during DONE.
                    state_next       = ST_DONE;
                    result_next      = code_reg;
                    result_gain_next = gain_reg;
                    ovr_next         = over_range;
                    udr_next         = (code_reg == '0);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            bit_reg         <= '0;
            code_reg        <= '0;
            gain_reg        <= '0;
            down_reg        <= 1'b0;
            result_reg      <= '0;
            result_gain_reg <= '0;
            ovr_reg         <= 1'b0;
            udr_reg         <= 1'b0;
            comp_meta_reg   <= 1'b0;
            comp_s_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            bit_reg         <= bit_next;
            code_reg        <= code_next;
            gain_reg        <= gain_next;
            down_reg        <= down_next;
            result_reg      <= result_next;
            result_gain_reg <= result_gain_next;
            ovr_reg         <= ovr_next;
            udr_reg         <= udr_next;
            comp_meta_reg   <= comp;
            comp_s_reg      <= comp_meta_reg;
        end
    end

    assign sample      = (state_reg == ST_SAMPLE);
    assign busy        = (state_reg == ST_SAMPLE) || (state_reg == ST_CONV) || (state_reg == ST_EVAL);
    assign done        = (state_reg == ST_DONE);
    assign gain        = gain_reg;
    assign result      = result_reg;
    assign result_gain = result_gain_reg;
    assign ovr         = ovr_reg;
    assign udr         = udr_reg;

    // In IDLE the DAC parks on the last result; while tracking it is zero.
    assign dac_code = (state_reg == ST_IDLE)   ? result_reg :
                      (state_reg == ST_SAMPLE) ? '0 :
                      (state_reg == ST_CONV)   ? (code_reg | bit_mask) :
                                                 code_reg;

endmodule

// File: tb/tb_instamp_sar_ctrl.sv
module tb_instamp_sar_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       autorange_en;
    logic       comp;
    logic [7:0] dac_code;
    logic       sample;
    logic [1:0] gain;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [1:0] result_gain;
    logic       ovr;
    logic       udr;

    instamp_sar_ctrl #(
        .WIDTH(8), .GAIN_BITS(2), .SAMPLE_CYC(8), .SETTLE_CYC(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .autorange_en(autorange_en),
        .comp(comp), .dac_code(dac_code), .sample(sample), .gain(gain),
        .busy(busy), .done(done), .result(result), .result_gain(result_gain),
        .ovr(ovr), .udr(udr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Analog environment: per-pass input voltage (in LSB), amplified by 2^gain
    // and clipped at full scale. The amp output sits half an LSB above that
    // integer value, so comp = (amp + 0.5 > dac) which is amp >= dac.
    int vin_pass [4];
    int pass_idx;
    int pidx_c;

    function automatic int amp_of(input int v, input int g);
        int a;
        a = v * (1 << g);
        return (a > 255) ? 255 : a;
    endfunction

    always_comb begin
        pidx_c = pass_idx;
        if (pidx_c < 0) pidx_c = 0;
        if (pidx_c > 3) pidx_c = 3;
        comp = (amp_of(vin_pass[pidx_c], int'(gain)) >= int'(dac_code));
    end

    typedef struct {
        int res;
        int rg;
        int ovr;
        int udr;
        int done_cyc;
        int samp;
        int busy;
    } exp_t;

    exp_t sbq[$];
    int   model_gain;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: each pass digitises clip(v * 2^g); autoranging steps down on
    // full scale, steps up below a quarter of full scale unless a down-step
    // already happened in this request.
    task automatic predict(input bit ar, input int start_edge);
        exp_t e;
        int g, p, a;
        bit dn;
        g = model_gain; p = 0; dn = 0;
        forever begin
            a = amp_of(vin_pass[(p > 3) ? 3 : p], g);
            if (ar && a == 255 && g > 0) begin
                g--; dn = 1; p++;
            end else if (ar && a < 64 && g < 3 && !dn) begin
                g++; p++;
            end else begin
                break;
            end
        end
        e.res      = a;
        e.rg       = g;
        e.ovr      = (a == 255) ? 1 : 0;
        e.udr      = (a == 0) ? 1 : 0;
        e.done_cyc = start_edge + 41 + 41 * p;
        e.busy     = 41 + 41 * p;
        e.samp     = 8 * (p + 1);
        model_gain = g;
        sbq.push_back(e);
    endtask

    task automatic set_vin(input int v0, input int v1, input int v2, input int v3);
        vin_pass[0] = v0; vin_pass[1] = v1; vin_pass[2] = v2; vin_pass[3] = v3;
    endtask

    // Called on a negedge: start is sampled at the coming posedge.
    task automatic issue(input bit ar);
        autorange_en = ar;
        pass_idx = -1;
        start = 1'b1;
        predict(ar, cyc + 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("done_timeout", sbq.size(), 0);
            sbq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pass tracking, busy/sample accounting, scoreboard compare on done.
    initial begin
        int busy_cnt, samp_cnt, txn, idle_res;
        bit samp_prev, idle_chk;
        exp_t e;
        busy_cnt = 0; samp_cnt = 0; txn = 0; samp_prev = 0; idle_chk = 0; idle_res = 0;
        forever begin
            @(negedge clk);
            if (sample && !samp_prev) pass_idx = pass_idx + 1;
            samp_prev = sample;
            if (rst) begin
                busy_cnt = 0; samp_cnt = 0; idle_chk = 0;
            end else begin
                if (idle_chk) begin
                    chk("idle_dac", int'(dac_code), idle_res);
                    idle_chk = 0;
                end
                if (busy) busy_cnt++;
                if (sample) samp_cnt++;
                if (done) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        txn++;
                        $display("txn %0d: cyc=%0d result=0x%02h rgain=%0d ovr=%0d udr=%0d busy=%0d",
                                 txn, cyc, result, result_gain, ovr, udr, busy_cnt);
                        chk("result", int'(result), e.res);
                        chk("result_gain", int'(result_gain), e.rg);
                        chk("gain", int'(gain), e.rg);
                        chk("ovr", int'(ovr), e.ovr);
                        chk("udr", int'(udr), e.udr);
                        chk("done_cycle", cyc, e.done_cyc);
                        chk("busy_cycles", busy_cnt, e.busy);
                        chk("sample_cycles", samp_cnt, e.samp);
                        idle_chk = 1;
                        idle_res = e.res;
                    end
                    busy_cnt = 0; samp_cnt = 0;
                end
            end
        end
    end

    initial begin
        int n2, v;
        rst = 1'b1; start = 1'b0; autorange_en = 1'b0; pass_idx = -1;
        set_vin(0, 0, 0, 0);
        model_gain = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sample", int'(sample), 0);
        chk("rst_dac", int'(dac_code), 0);
        chk("rst_gain", int'(gain), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_flags", int'({ovr, udr}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Plain conversion with restart pulses that must be ignored.
        set_vin(8'hA5, 8'hA5, 8'hA5, 8'hA5);
        issue(1'b0);
        repeat (8) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (19) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done();
        repeat (60) @(negedge clk);

        // Autorange up: 20 -> 40 -> 80 at gain 2.
        set_vin(20, 20, 20, 20);
        issue(1'b1);
        wait_done();
        // Drive gain to 3 with a zero input.
        set_vin(0, 0, 0, 0);
        issue(1'b1);
        wait_done();
        // Down-steps: 255, 255, then 200 at gain 1.
        set_vin(100, 100, 100, 100);
        issue(1'b1);
        wait_done();
        // Down-step then underrange in same request: must not step back up.
        set_vin(200, 10, 10, 10);
        issue(1'b1);
        wait_done();

        // Autorange off: clip and zero with gain held.
        set_vin(300, 300, 300, 300);
        issue(1'b0);
        wait_done();
        set_vin(0, 0, 0, 0);
        issue(1'b0);
        wait_done();

        // start held high: second request begins right after returning to IDLE.
        set_vin(77, 77, 77, 77);
        autorange_en = 1'b0;
        pass_idx = -1;
        start = 1'b1;
        predict(1'b0, cyc + 1);
        n2 = cyc + 1 + 43;
        predict(1'b0, n2);
        while (cyc < n2) @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset mid-conversion.
        set_vin(150, 150, 150, 150);
        issue(1'b0);
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sbq.delete();
        model_gain = 0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_dac", int'(dac_code), 0);
        chk("abort_gain", int'(gain), 0);
        chk("abort_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_vin(8'h5A, 8'h5A, 8'h5A, 8'h5A);
        issue(1'b0);
        wait_done();

        // Randomised requests.
        for (int k = 0; k < 14; k++) begin
            v = int'($urandom_range(0, 300));
            if ($urandom_range(0, 3) == 0)
                set_vin(v, int'($urandom_range(0, 300)), int'($urandom_range(0, 300)),
                        int'($urandom_range(0, 300)));
            else
                set_vin(v, v, v, v);
            issue(1'($urandom_range(0, 1)));
            wait_done();
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
